// File: rtl/sram_rr_arbiter_pkg.sv
// Shared types for the two-requester sram arbiter.
// Requester indices are named so last-grant bookkeeping reads clearly.
package sram_rr_arbiter_pkg;

   typedef enum logic {
      REQ0 = 1'b0,
      REQ1 = 1'b1
   } req_idx_e;

endpackage

// File: rtl/sram_rr_arbiter_rr_arb2.sv
// Two-way round-robin grant logic; purely combinational.
// On a tie, the requester that did not win last time is granted.
import sram_rr_arbiter_pkg::*;

module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_gnt == REQ0) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Shares one single-port sram between two requesters with round-robin fairness,
// routes read data back to the issuing requester and counts stall cycles.
import sram_rr_arbiter_pkg::*;

module sram_rr_arbiter #(
   parameter int NUM    = 2048,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16,
   localparam int AW    = $clog2(NUM)
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [AW-1:0]     addr0,
   input  logic [AW-1:0]     addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic [CNT_W-1:0]  stall0,
   output logic [CNT_W-1:0]  stall1,
   output logic              sram_CEN,
   output logic              sram_WEN,
   output logic [AW-1:0]     sram_A,
   output logic [DATA_W-1:0] sram_D,
   input  logic [DATA_W-1:0] sram_Q
);

   req_idx_e   last_gnt;
   logic [1:0] arb_gnt;

   rr_arb2 u_arb (
      .req      ({req1, req0}),
      .last_gnt (last_gnt),
      .gnt      (arb_gnt)
   );

   // Grants are suppressed during reset so the sram sees no access.
   assign gnt0  = RESET_N & arb_gnt[0];
   assign gnt1  = RESET_N & arb_gnt[1];
   assign rdata = sram_Q;

   always_comb begin
      sram_CEN = 1'b1;
      sram_WEN = 1'b1;
      sram_A   = addr0;
      sram_D   = wdata0;
      if (gnt1) begin
         sram_CEN = 1'b0;
         sram_WEN = ~we1;
         sram_A   = addr1;
         sram_D   = wdata1;
      end else if (gnt0) begin
         sram_CEN = 1'b0;
         sram_WEN = ~we0;
      end
   end

   // Sram read latency is one cycle, so rvalid is the granted read delayed by one edge.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         last_gnt <= REQ1;
         rvalid0  <= 1'b0;
         rvalid1  <= 1'b0;
      end else begin
         if (gnt0) begin
            last_gnt <= REQ0;
         end else if (gnt1) begin
            last_gnt <= REQ1;
         end
         rvalid0 <= gnt0 & ~we0;
         rvalid1 <= gnt1 & ~we1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         stall0 <= '0;
         stall1 <= '0;
      end else begin
         if (req0 && !gnt0 && (stall0 != '1)) begin
            stall0 <= stall0 + CNT_W'(1);
         end
         if (req1 && !gnt1 && (stall1 != '1)) begin
            stall1 <= stall1 + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter with a behavioural sram and a transaction-level reference model.
module tb_sram_rr_arbiter;

   localparam int NUM = 4096;
   localparam int DW  = 64;
   localparam int CW  = 4;
   localparam int AW  = 12;

   logic          CLK;
   logic          RESET_N;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, rvalid0, rvalid1;
   logic [DW-1:0] rdata;
   logic [CW-1:0] stall0, stall1;
   logic          sram_CEN, sram_WEN;
   logic [AW-1:0] sram_A;
   logic [DW-1:0] sram_D, sram_Q;

   sram_rr_arbiter #(.NUM(NUM), .DATA_W(DW), .CNT_W(CW)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .stall0(stall0), .stall1(stall1),
      .sram_CEN(sram_CEN), .sram_WEN(sram_WEN), .sram_A(sram_A),
      .sram_D(sram_D), .sram_Q(sram_Q)
   );

   logic [DW-1:0] sram_mem [NUM];
   always @(posedge CLK) begin
      if (!sram_CEN) begin
         if (!sram_WEN) sram_mem[sram_A] <= sram_D;
         else           sram_Q <= sram_mem[sram_A];
      end
   end

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model: what the sram should hold, who won last, what read is due back.
   logic [DW-1:0] m_mem [NUM];
   int            m_last = 1;
   bit            m_known = 0;
   bit            m_rv0 = 0, m_rv1 = 0;
   logic [DW-1:0] m_rdata;
   int            m_stall0 = 0, m_stall1 = 0;
   int            n_cmp = 0, n_bad = 0;
   logic [AW-1:0] pool [8];

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit rst, input bit r0, input bit w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input bit r1, input bit w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1, output int g);
      bit            gw;
      logic [AW-1:0] ga;
      logic [DW-1:0] gd;
      RESET_N = rst;
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      #1;
      g = -1;
      if (rst) begin
         if (r0 && r1) g = (m_last == 0) ? 1 : 0;
         else if (r0)  g = 0;
         else if (r1)  g = 1;
      end
      gw = (g == 1) ? w1 : w0;
      ga = (g == 1) ? a1 : a0;
      gd = (g == 1) ? d1 : d0;
      check("gnt0", DW'(gnt0), DW'(g == 0));
      check("gnt1", DW'(gnt1), DW'(g == 1));
      check("sram_CEN", DW'(sram_CEN), DW'(g < 0));
      if (g >= 0) begin
         check("sram_WEN", DW'(sram_WEN), DW'(!gw));
         check("sram_A", DW'(sram_A), DW'(ga));
         if (gw) check("sram_D", sram_D, gd);
      end
      if (m_known) begin
         check("rvalid0", DW'(rvalid0), DW'(m_rv0));
         check("rvalid1", DW'(rvalid1), DW'(m_rv1));
         check("stall0", DW'(stall0), DW'(m_stall0));
         check("stall1", DW'(stall1), DW'(m_stall1));
         if (m_rv0 || m_rv1) check("rdata", rdata, m_rdata);
      end
      @(posedge CLK);
      if (!rst) begin
         m_last = 1; m_rv0 = 0; m_rv1 = 0;
         m_stall0 = 0; m_stall1 = 0;
         m_known = 1;
      end else begin
         if (r0 && g != 0 && m_stall0 < (1 << CW) - 1) m_stall0++;
         if (r1 && g != 1 && m_stall1 < (1 << CW) - 1) m_stall1++;
         m_rv0 = (g == 0) && !gw;
         m_rv1 = (g == 1) && !gw;
         if (g >= 0) begin
            m_last = g;
            if (gw) m_mem[ga] = gd;
            else    m_rdata = m_mem[ga];
         end
      end
      @(negedge CLK);
   endtask

   initial begin
      int            g;
      bit            act0, act1, aw0, aw1;
      logic [AW-1:0] aa0, aa1;
      logic [DW-1:0] ad0, ad1;
      pool = '{12'h005, 12'h010, 12'h810, 12'h7FE, 12'h7FF, 12'h800, 12'h801, 12'hFFF};
      RESET_N = 1'b0;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      @(negedge CLK);

      $display("[TB] reset with both requesting");
      for (int i = 0; i < 3; i++) step(0, 1, 0, 12'h010, '0, 1, 0, 12'h810, '0, g);

      $display("[TB] solo write then read");
      step(1, 1, 1, 12'h005, {8{8'hA5}}, 0, 0, '0, '0, g);
      step(1, 1, 0, 12'h005, '0, 0, 0, '0, '0, g);
      step(1, 0, 0, '0, '0, 0, 0, '0, '0, g);
      check("solo_rdata", rdata, {8{8'hA5}});

      $display("[TB] preload address pool");
      for (int i = 1; i < 8; i++)
         step(1, 1, 1, pool[i], {$urandom, $urandom}, 0, 0, '0, '0, g);

      $display("[TB] contention after reset");
      step(0, 0, 0, '0, '0, 0, 0, '0, '0, g);
      for (int i = 0; i < 6; i++) step(1, 1, 0, 12'h010, '0, 1, 0, 12'h810, '0, g);
      step(1, 0, 0, '0, '0, 0, 0, '0, '0, g);
      check("contention_stall0", DW'(stall0), DW'(3));
      check("contention_stall1", DW'(stall1), DW'(3));

      $display("[TB] bank crossing");
      step(1, 0, 0, '0, '0, 1, 1, 12'h7FF, 64'h1111_2222_3333_4444, g);
      step(1, 0, 0, '0, '0, 1, 1, 12'h800, 64'h5555_6666_7777_8888, g);
      step(1, 1, 0, 12'h7FF, '0, 0, 0, '0, '0, g);
      step(1, 1, 0, 12'h800, '0, 0, 0, '0, '0, g);
      check("bank_rdata_hi", rdata, 64'h5555_6666_7777_8888);
      step(1, 0, 0, '0, '0, 0, 0, '0, '0, g);

      $display("[TB] reset while req1 reads");
      step(0, 0, 0, '0, '0, 1, 0, 12'h810, '0, g);
      step(1, 1, 0, 12'h005, '0, 1, 0, 12'h810, '0, g);
      step(1, 0, 0, '0, '0, 1, 0, 12'h810, '0, g);
      step(1, 0, 0, '0, '0, 0, 0, '0, '0, g);

      $display("[TB] stall counter saturation");
      step(0, 0, 0, '0, '0, 0, 0, '0, '0, g);
      for (int i = 0; i < 40; i++) step(1, 1, 0, 12'h7FE, '0, 1, 0, 12'h801, '0, g);
      step(1, 0, 0, '0, '0, 0, 0, '0, '0, g);
      check("sat_stall1", DW'(stall1), DW'(15));

      $display("[TB] randomized traffic");
      act0 = 0; act1 = 0;
      aw0 = 0; aw1 = 0; aa0 = '0; aa1 = '0; ad0 = '0; ad1 = '0;
      for (int i = 0; i < 400; i++) begin
         if (!act0 && $urandom_range(0, 9) < 6) begin
            act0 = 1; aw0 = $urandom_range(0, 1) == 1;
            aa0 = pool[$urandom_range(0, 7)]; ad0 = {$urandom, $urandom};
         end else if (act0 && $urandom_range(0, 19) == 0) act0 = 0;
         if (!act1 && $urandom_range(0, 9) < 6) begin
            act1 = 1; aw1 = $urandom_range(0, 1) == 1;
            aa1 = pool[$urandom_range(0, 7)]; ad1 = {$urandom, $urandom};
         end else if (act1 && $urandom_range(0, 19) == 0) act1 = 0;
         step($urandom_range(0, 63) != 0, act0, aw0, aa0, ad0, act1, aw1, aa1, ad1, g);
         if (g == 0) act0 = 0;
         if (g == 1) act1 = 0;
      end
      step(1, 0, 0, '0, '0, 0, 0, '0, '0, g);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
